// File: rtl/poly_mac_acc.sv
// poly_mac_acc: streaming polynomial multiply-accumulate.
// R = D * A over Z_(2^QW)[x]/(x^N - 1). Define NEGACYCLIC_EN to reduce
// modulo (x^N + 1) instead; ports and timing are the same in both builds.
// A is latched when a run starts. D then arrives one coefficient per valid
// cycle, lowest index first. Each accepted d_j adds d_j * (A * x^j) into the
// accumulator, and A is rotated one place after every accepted coefficient.
module poly_mac_acc #(
  parameter int N  = 4,
  parameter int DW = 4,
  parameter int AW = 4,
  parameter int QW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [N*AW-1:0] a_in,
  input  logic [DW-1:0]   dcoef,
  input  logic            din_valid,
  output logic            csr_load,
  output logic            busy,
  output logic            done,
  output logic [N*QW-1:0] result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

`ifdef NEGACYCLIC_EN
  // The wrapped-around coefficient is negated, so it needs the full result width.
  localparam int ARW = QW;
`else
  localparam int ARW = AW;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_accept;
  logic            w_take;
  logic [ARW-1:0]  w_feedback;
  logic [ARW-1:0]  r_a_rot [N];
  logic [QW-1:0]   r_acc   [N];
  logic [CW-1:0]   r_cnt;
  logic            r_csr_load;
  logic            r_busy;
  logic            r_done;

`ifdef NEGACYCLIC_EN
  // Multiplying by x wraps x^N to -1.
  assign w_feedback = {ARW{1'b0}} - r_a_rot[N-1];
`else
  // Multiplying by x wraps x^N to +1.
  assign w_feedback = r_a_rot[N-1];
`endif

  // Next-state logic, start acceptance and coefficient acceptance.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_take       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (din_valid) begin
          w_take = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_RUN;
          end
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_csr_load <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_csr_load <= w_accept;
      r_busy     <= (w_next_state == S_RUN);
      r_done     <= (w_next_state == S_DONE);
    end
  end

  // Datapath: latch A on start, then accumulate and rotate per valid coefficient.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        r_a_rot[k] <= {ARW{1'b0}};
        r_acc[k]   <= {QW{1'b0}};
      end
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        r_a_rot[k] <= ARW'(a_in[k*AW +: AW]);
        r_acc[k]   <= {QW{1'b0}};
      end
      r_cnt <= {CW{1'b0}};
    end else if (w_take) begin
      for (int k = 0; k < N; k++) begin
        r_acc[k] <= r_acc[k] + QW'(dcoef) * QW'(r_a_rot[k]);
      end
      for (int k = 1; k < N; k++) begin
        r_a_rot[k] <= r_a_rot[k-1];
      end
      r_a_rot[0] <= w_feedback;
      r_cnt      <= r_cnt + CW'(1);
    end
  end

  assign csr_load = r_csr_load;
  assign busy     = r_busy;
  assign done     = r_done;

  for (genvar g = 0; g < N; g++) begin : g_result
    assign result[g*QW +: QW] = r_acc[g];
  end

endmodule
